// File: rtl/snn_pkg.sv
// Shared sizing and types for the spike delay line.
// The channel count and delay width are fixed here; DEPTH follows from DLY_W.
package snn_pkg;

    localparam int unsigned NUM_IN = 8;
    localparam int unsigned DLY_W  = 3;
    localparam int unsigned DEPTH  = 2 ** DLY_W;
    localparam int unsigned ADDR_W = $clog2(NUM_IN);

    typedef logic [NUM_IN-1:0] spike_vec_t;
    typedef logic [DLY_W-1:0]  delay_t;

endpackage

// File: rtl/snn_delay_tap.sv
// One channel of the delay line.
// Holds the spike history, the delay register and the registered tap output.
module snn_delay_tap
    import snn_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   step_i,
    input  logic   spike_i,
    input  logic   dly_we_i,
    input  delay_t dly_i,
    output logic   spike_o
);

    logic [DEPTH-1:0] history_d, history_q;
    delay_t           delay_d, delay_q;
    logic             out_d, out_q;

    always_comb begin
        history_d = history_q;
        out_d     = out_q;
        delay_d   = delay_q;
        if (step_i) begin
            history_d = {history_q[DEPTH-2:0], spike_i};
            // Tap the post-shift history with the old delay, so delay 0 returns the new spike
            // and a delay written on the same edge only applies from the next step.
            out_d     = history_d[delay_q];
        end
        if (dly_we_i) begin
            delay_d = dly_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            history_q <= '0;
            delay_q   <= '0;
            out_q     <= 1'b0;
        end else begin
            history_q <= history_d;
            delay_q   <= delay_d;
            out_q     <= out_d;
        end
    end

    assign spike_o = out_q;

endmodule

// File: rtl/snn_spike_delay_line.sv
// Per-channel programmable axonal delay between the spike inputs and the neuron layer.
// Decodes config writes, drives the output valid strobe and instantiates one tap per channel.
module snn_spike_delay_line
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  spike_vec_t        spikes_in,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  delay_t            cfg_delay,
    output logic              cfg_ready,
    output spike_vec_t        spikes_out,
    output logic              spikes_out_valid
);

    logic       cfg_ready_d, cfg_ready_q;
    logic       valid_d, valid_q;
    logic       cfg_fire;
    spike_vec_t dly_we;

    always_comb begin
        cfg_ready_d = 1'b1;
        valid_d     = step;
        cfg_fire    = cfg_valid && cfg_ready_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            cfg_ready_q <= cfg_ready_d;
            valid_q     <= valid_d;
        end
    end

    assign cfg_ready        = cfg_ready_q;
    assign spikes_out_valid = valid_q;

    // Out-of-range addresses match no channel, so such writes are accepted and dropped.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_tap
        assign dly_we[i] = cfg_fire && (cfg_addr == ADDR_W'(i));

        snn_delay_tap u_tap (
            .clk_i    (clk),
            .rst_i    (rst),
            .step_i   (step),
            .spike_i  (spikes_in[i]),
            .dly_we_i (dly_we[i]),
            .dly_i    (cfg_delay),
            .spike_o  (spikes_out[i])
        );
    end

endmodule

// File: tb/tb_snn_spike_delay_line.sv
// Directed self-checking bench for snn_spike_delay_line.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_snn_spike_delay_line;
    import snn_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              step;
    spike_vec_t        spikes_in;
    logic              cfg_valid;
    logic [ADDR_W-1:0] cfg_addr;
    delay_t            cfg_delay;
    logic              cfg_ready;
    spike_vec_t        spikes_out;
    logic              spikes_out_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    snn_spike_delay_line dut (
        .clk              (clk),
        .rst              (rst),
        .step             (step),
        .spikes_in        (spikes_in),
        .cfg_valid        (cfg_valid),
        .cfg_addr         (cfg_addr),
        .cfg_delay        (cfg_delay),
        .cfg_ready        (cfg_ready),
        .spikes_out       (spikes_out),
        .spikes_out_valid (spikes_out_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 1'b0; spikes_in = '0; cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_cfg(input logic [ADDR_W-1:0] addr, input delay_t dly);
        cfg_valid = 1'b1; cfg_addr = addr; cfg_delay = dly;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_step(input spike_vec_t v);
        step = 1'b1; spikes_in = v;
        tick();
        step = 1'b0; spikes_in = '0;
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; spikes_in = '0;
        cfg_valid = 1'b0; cfg_addr = '0; cfg_delay = '0;

        // 1. Reset state, then pass-through with all delays 0.
        tick();
        check("rst_out", spikes_out, 8'h00);
        check("rst_valid", {7'd0, spikes_out_valid}, 8'h00);
        check("rst_ready", {7'd0, cfg_ready}, 8'h00);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {7'd0, cfg_ready}, 8'h01);
        do_step(8'hA5);
        check("pass_out", spikes_out, 8'hA5);
        check("pass_valid", {7'd0, spikes_out_valid}, 8'h01);
        tick();
        check("idle_valid", {7'd0, spikes_out_valid}, 8'h00);
        check("idle_hold", spikes_out, 8'hA5);

        // 2. Channel 2 delayed by 3 steps.
        do_reset();
        do_cfg(3'd2, 3'd3);
        do_step(8'h04);
        check("d3_p1", spikes_out, 8'h00);
        do_step(8'h00);
        check("d3_p2", spikes_out, 8'h00);
        do_step(8'h00);
        check("d3_p3", spikes_out, 8'h00);
        do_step(8'h00);
        check("d3_p4", spikes_out, 8'h04);
        check("d3_p4_valid", {7'd0, spikes_out_valid}, 8'h01);

        // 3. Maximum delay, then the spike is shifted out for good.
        do_reset();
        do_cfg(3'd0, 3'd7);
        do_step(8'h01);
        check("d7_p1", spikes_out, 8'h00);
        for (int k = 2; k <= 7; k++) begin
            do_step(8'h00);
            check("d7_mid", spikes_out, 8'h00);
        end
        do_step(8'h00);
        check("d7_p8", spikes_out, 8'h01);
        do_step(8'h00);
        check("d7_p9_lost", spikes_out, 8'h00);
        do_cfg(3'd0, 3'd7);
        do_step(8'h00);
        check("d7_p10_lost", spikes_out, 8'h00);

        // 4. Config and step on the same edge: old delay applies to that step.
        do_reset();
        cfg_valid = 1'b1; cfg_addr = 3'd5; cfg_delay = 3'd2;
        do_step(8'h20);
        cfg_valid = 1'b0;
        check("coll_p1_old", spikes_out, 8'h20);
        do_step(8'h00);
        check("coll_p2", spikes_out, 8'h00);
        do_step(8'h00);
        check("coll_p3_new", spikes_out, 8'h20);

        // 5. Back-to-back steps, valid stays high throughout.
        do_reset();
        step = 1'b1;
        spikes_in = 8'h01; tick();
        check("b2b_0", spikes_out, 8'h01);
        check("b2b_v0", {7'd0, spikes_out_valid}, 8'h01);
        spikes_in = 8'h02; tick();
        check("b2b_1", spikes_out, 8'h02);
        check("b2b_v1", {7'd0, spikes_out_valid}, 8'h01);
        spikes_in = 8'h04; tick();
        check("b2b_2", spikes_out, 8'h04);
        check("b2b_v2", {7'd0, spikes_out_valid}, 8'h01);
        spikes_in = 8'h08; tick();
        check("b2b_3", spikes_out, 8'h08);
        check("b2b_v3", {7'd0, spikes_out_valid}, 8'h01);
        step = 1'b0; spikes_in = '0; tick();
        check("b2b_end_valid", {7'd0, spikes_out_valid}, 8'h00);

        // 6. Reset coincident with a step and a config write takes priority.
        do_reset();
        do_cfg(3'd1, 3'd4);
        do_step(8'h02);
        check("mid_pre", spikes_out, 8'h00);
        rst = 1'b1; step = 1'b1; spikes_in = 8'h02;
        cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_delay = 3'd4;
        tick();
        check("mid_rst_out", spikes_out, 8'h00);
        check("mid_rst_valid", {7'd0, spikes_out_valid}, 8'h00);
        check("mid_rst_ready", {7'd0, cfg_ready}, 8'h00);
        rst = 1'b0; step = 1'b0; spikes_in = '0; cfg_valid = 1'b0;
        tick();
        check("mid_ready", {7'd0, cfg_ready}, 8'h01);
        do_step(8'h02);
        check("mid_pass", spikes_out, 8'h02);
        for (int k = 0; k < 6; k++) begin
            do_step(8'h00);
            check("mid_no_ghost", spikes_out, 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
